// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one registered adder.
// Optional carry-out port rsp_ovf enabled by `define ADDER_ARB_OVF_EN.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   req_valid/ready    per-requester handshake (ready one-hot or zero)
//   req_a, req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready    response handshake
//   rsp_id, rsp_sum    owner tag and wrapped sum of the response
//   rsp_ovf            carry-out (only with ADDER_ARB_OVF_EN)
//   busy               high whenever the sequencer is not idle

module adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sum <= '0;
    else       sum <= a + b;
  end

endmodule

module adder_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
`ifdef ADDER_ARB_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   tag;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;

  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;

  logic st_idle;
  logic st_issue;
  logic st_wait;
  logic st_resp;

  assign st_idle  = (state == S_IDLE);
  assign st_issue = (state == S_ISSUE);
  assign st_wait  = (state == S_WAIT);
  assign st_resp  = (state == S_RESP);

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .clk  (clk),
    .rstn (rstn),
    .a    (op_a),
    .b    (op_b),
    .sum  (sum)
  );

  // Search starts one past the last winner and wraps,
  // so the first hit in the loop is the round-robin winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Operand mux by constant slices to keep the
  // index arithmetic out of the part-selects.
  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        pick_a = req_a[i*WIDTH +: WIDTH];
        pick_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grants only while idle; held low during reset.
  always_comb begin
    req_ready = '0;
    if (rstn && st_idle && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NREQ - 1);
      tag        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (gnt_any) begin
            op_a       <= pick_a;
            op_b       <= pick_b;
            tag        <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= S_ISSUE;
          end
        end
        st_issue: begin
          state <= S_WAIT;
        end
        st_wait: begin
          rsp_sum   <= sum;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        st_resp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_id = tag;
  assign busy   = !st_idle;

`ifdef ADDER_ARB_OVF_EN
  // A wrapped sum is smaller than either operand
  // exactly when the WIDTH+1 bit sum carries out.
  logic carry;

  assign carry = (op_a + op_b) < op_a;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_ovf <= 1'b0;
    end else if (st_wait) begin
      rsp_ovf <= carry;
    end
  end
`else
  // Carry-out is not tracked in this build.
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter.
// Directed scenarios followed by randomized traffic.

module tb_adder_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [W-1:0] rsp_sum;
  logic         busy;
`ifdef ADDER_ARB_OVF_EN
  logic         rsp_ovf;
`endif

  adder_arbiter #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
`ifdef ADDER_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   nchecks = 0;
  int   nfail = 0;

  function automatic void chk(string nm, int act, int exp);
    nchecks++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    nchecks++;
    nfail++;
    $display("FAIL %s", nm);
  endfunction

  // First requesting index after 'last', wrapping; -1 if none.
  function automatic int rr(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Reference model: idle -> accept, two cycles of latency,
  // then the response is held until the consumer takes it.
  int m_last = N - 1;
  bit m_idle = 1'b1;
  bit m_resp = 1'b0;
  int m_left = 0;

  always @(posedge clk or negedge rstn) begin : model
    int g;
    int s;
    if (!rstn) begin
      m_last <= N - 1;
      m_idle <= 1'b1;
      m_resp <= 1'b0;
      m_left <= 0;
      sb.delete();
      glog.delete();
    end else if (m_idle) begin
      g = rr(req_valid, m_last);
      if (g >= 0) begin
        s = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
        sb.push_back('{g, s % 256, (s > 255) ? 1 : 0});
        m_last <= g;
        m_idle <= 1'b0;
        m_left <= 2;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_resp <= 1'b1;
    end else if (rsp_ready) begin
      m_resp <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  logic [N-1:0] acc = '0;
  logic [N-1:0] acc_edge = '0;

  always @(negedge clk) begin : monitor
    logic [N-1:0] er;
    int g;
    if (!rstn) begin
      acc <= '0;
    end else begin
      er = '0;
      g = rr(req_valid, m_last);
      if (m_idle && g >= 0) er[g] = 1'b1;
      chk("req_ready", int'(req_ready), int'(er));
      chk("rsp_valid", int'(rsp_valid), int'(m_resp));
      chk("busy", int'(busy), int'(!m_idle));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          chk("rsp_id", int'(rsp_id), sb[0].id);
          chk("rsp_sum", int'(rsp_sum), sb[0].sum);
`ifdef ADDER_ARB_OVF_EN
          chk("rsp_ovf", int'(rsp_ovf), sb[0].ovf);
`endif
          if (rsp_ready) void'(sb.pop_front());
        end
      end
      acc <= req_valid & req_ready;
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k]) glog.push_back(k);
      end
    end
  end

  bit refill = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
    acc_edge = acc;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && !refill) req_valid[i] = 1'b0;
    end
  endtask

  task automatic put(int i, int a, int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic wait_acc(string nm);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (acc_edge == '0 && n < 30);
    if (acc_edge == '0) fail(nm);
  endtask

  task automatic one(int i, int a, int b, int es, int eo, string nm);
    put(i, a, b);
    req_valid[i] = 1'b1;
    rsp_ready = 1'b1;
    wait_acc({nm, "_acc"});
    chk({nm, "_gnt"}, int'(acc_edge), 1 << i);
    cyc();
    chk({nm, "_early"}, int'(rsp_valid), 0);
    cyc();
    chk({nm, "_valid"}, int'(rsp_valid), 1);
    chk({nm, "_id"}, int'(rsp_id), i);
    chk({nm, "_sum"}, int'(rsp_sum), es);
`ifdef ADDER_ARB_OVF_EN
    chk({nm, "_ovf"}, int'(rsp_ovf), eo);
`else
    if (eo < 0) fail({nm, "_ovf_arg"});
`endif
    cyc();
    cyc();
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    #12;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_sum", int'(rsp_sum), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_req_ready", int'(req_ready), 0);
`ifdef ADDER_ARB_OVF_EN
    chk("rst_rsp_ovf", int'(rsp_ovf), 0);
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc();

    one(0, 15, 10, 25, 0, "single");
    one(2, 200, 100, 44, 1, "wrap");
    one(2, 25, 30, 55, 0, "nowrap");

    // Backpressure
    rsp_ready = 1'b0;
    put(1, 77, 88);
    req_valid[1] = 1'b1;
    wait_acc("bp_acc");
    cyc();
    cyc();
    put(3, 1, 2);
    req_valid[3] = 1'b1;
    repeat (5) begin
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_sum", int'(rsp_sum), 165);
      chk("bp_id", int'(rsp_id), 1);
      chk("bp_ready", int'(req_ready), 0);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    chk("bp_regrant", int'(req_ready), 8);
    cyc();
    chk("bp_acc3", int'(acc_edge), 8);
    repeat (4) cyc();

    // Withdrawn request
    put(3, 5, 6);
    req_valid[3] = 1'b1;
    wait_acc("wd_acc3");
    chk("wd_gnt3", int'(acc_edge), 8);
    put(1, 9, 9);
    req_valid[1] = 1'b1;
    cyc();
    req_valid[1] = 1'b0;
    put(2, 7, 7);
    req_valid[2] = 1'b1;
    wait_acc("wd_acc2");
    chk("wd_gnt", int'(acc_edge), 4);
    repeat (4) cyc();

    // Reset during WAIT, then all four request
    put(0, 50, 60);
    req_valid[0] = 1'b1;
    wait_acc("mr_acc");
    cyc();
    #2;
    rstn = 1'b0;
    for (int i = 0; i < N; i++) put(i, 10 * i, i);
    req_valid = '1;
    #1;
    chk("mr_rsp_valid", int'(rsp_valid), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_rsp_sum", int'(rsp_sum), 0);
    chk("mr_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    refill = 1'b1;
    n = 0;
    while (glog.size() < 5 && n < 40) begin
      cyc();
      n++;
    end
    if (glog.size() < 5) begin
      fail("rr_timeout");
    end else begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_order%0d", k), glog[k], exp_order[k]);
      end
    end
    refill = 1'b0;
    req_valid = '0;
    repeat (6) cyc();

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      cyc();
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom % 3 == 0) begin
            put(i, int'($urandom % 256), int'($urandom % 256));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom % 16 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) cyc();
    chk("drain_queue", sb.size(), 0);
    chk("drain_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one registered `adder` instance (one-cycle latency, `sum <= a + b`, WIDTH bits, wraps) between NREQ requesters. Each requester presents an operand pair on a valid/ready handshake. The block drives the adder's `a`/`b`, waits out the adder latency, and returns the sum tagged with the requester index on a valid/ready response channel. It sits between the requesters and the `adder`, which it instantiates internally.

## Interface
- `WIDTH`, 8, operand and sum width; passed to the internal `adder`.
- `NREQ`, 4, number of requesters; legal range 2..16.
- `IDW`, `$clog2(NREQ)`, width of the response tag; localparam.
- `clk`  in  1  single clock; all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low; also drives the internal `adder`'s `rstn`.
- `req_valid`  in  NREQ  bit i: requester i has an operand pair.
- `req_ready`  out  NREQ  one-hot or zero; bit i: requester i accepted this cycle.
- `req_a`  in  NREQ*WIDTH  operand a; requester i at `[i*WIDTH +: WIDTH]`.
- `req_b`  in  NREQ*WIDTH  operand b; same packing as `req_a`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sum`  out  WIDTH  `(a + b) mod 2^WIDTH`.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is set, grant requester g and assert `req_ready[g]` combinationally this cycle.
  - At the clock edge: latch `req_a[g]`/`req_b[g]` into the adder operand registers, latch g as the tag, update `last_grant <= g`, go to ISSUE.
  - With no requests, `req_ready = 0` and the state stays IDLE.
- **ISSUE**: the adder registers the sum at this edge. Go to WAIT.
- **WAIT**: capture the adder's `sum` into `rsp_sum`, set `rsp_valid <= 1`, go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_id` and `rsp_sum` stable until `rsp_valid && rsp_ready`.
  - On that handshake: `rsp_valid <= 0`, go to IDLE.
  - No new grant is made in RESP.
- **Arbitration**
  - Round-robin. The search starts at `(last_grant + 1) mod NREQ`; the first set `req_valid` wins.
  - `last_grant` resets to NREQ-1, so requester 0 has top priority after reset.
- **Protocol rules**
  - A requester holds `req_valid` and its operands stable until it sees `req_ready`.
  - Operands are sampled only on the handshake edge.
  - Dropping `req_valid` before the grant is legal; that request is simply not granted.
- **Arithmetic**: the sum wraps modulo 2^WIDTH, with no saturation. Carry-out is visible only via the macro below.
- **Reset mid-operation**: an in-flight operation is discarded and no response is produced for it. All state returns to reset values.
- **Reset values**
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `busy = 0`.
  - `req_ready = 0`, adder operands 0, `last_grant = NREQ-1`.

## Timing
- Accept at edge N, then:
  - adder operands are valid after N;
  - adder sum is valid after N+1;
  - `rsp_valid` rises after N+2.
- Latency is 2 cycles from the accept edge to `rsp_valid`.
- Response handshake at edge M puts the state in IDLE after M. The next grant can happen in the cycle following M, accepted at edge M+1.
- Peak throughput with `rsp_ready` held high: one operation per 4 cycles.
- `req_ready` is a combinational function of the state, `req_valid` and `last_grant`. There is no combinational path from `req_a`/`req_b` to any output.
- `busy` is registered: high from the cycle after the accept edge until the cycle after the response handshake.

## Configuration
- `ADDER_ARB_OVF_EN`
  - **Defined**: adds output `rsp_ovf` (out, 1).
    - The block keeps the latched operands and computes the carry-out of their (WIDTH+1)-bit sum.
    - `rsp_ovf` is registered alongside `rsp_sum` in WAIT and held in RESP.
    - Reset value is 0.
  - **Undefined**: the port and its logic are absent; all other behaviour is identical.

## Test plan
Configuration for all scenarios: WIDTH=8, NREQ=4.

- **Single request**: `req_valid=4'b0001`, a=15, b=10, `rsp_ready=1` -> `req_ready[0]` is high in the accept cycle; `rsp_valid` is high 2 cycles after the accept edge with `rsp_id=0`, `rsp_sum=25`; `busy` returns low afterwards.
- **Round-robin fairness**: all four requesters hold `req_valid` continuously with distinct operands (i: a=10*i, b=i) -> grant order is 0,1,2,3,0; each response carries the matching id and sum, e.g. id 2 gives 22.
- **Wrap-around**: a=200, b=100 -> `rsp_sum=44`. With `ADDER_ARB_OVF_EN`, `rsp_ovf=1`; for a=25, b=30, `rsp_ovf=0` and `rsp_sum=55`.
- **Backpressure**: `rsp_ready=0` for 5 cycles after `rsp_valid` -> `rsp_valid`, `rsp_id` and `rsp_sum` stay stable; `req_ready` stays 0 even with a pending request; the grant follows the cycle after the handshake.
- **Reset mid-operation**: assert `rstn=0` during WAIT -> `rsp_valid=0`, `busy=0`, `rsp_sum=0` immediately; no response is produced after release; the first post-reset grant goes to requester 0 when all requesters request.
- **Request withdrawn**: requester 1 drops `req_valid` while requester 3 is being serviced -> no grant to 1; the next grant goes to the next requester with `req_valid` set.
